rice_core_bp_update_scheduler: RTL and testbench
================================================

Name: rice_core_bp_update_scheduler

Overview:
Sits between the branch-resolving pipeline stages and the branch predictor (PHT + BTB), which has a single update port. It buffers branch results from two requesters in per-requester FIFOs and issues at most one predictor update per cycle using round-robin arbitration. It also sequences predictor enable by walking a clear index through every table entry before updates are allowed.

Parameters:
XLEN, 32, address/PC width
ENTRIES, 128, number of predictor entries to clear; power of two, at least 2
INDEX_WIDTH, $clog2(ENTRIES), clear index width (derived)
FIFO_DEPTH, 2, entries per requester FIFO; power of two, at least 1

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_enable  input  1  predictor enable request
i_req_valid  input  2  per-requester result valid
o_req_ready  output  2  per-requester ready
i_req_pc  input  2xXLEN  branch PC per requester
i_req_target_pc  input  2xXLEN  resolved target per requester
i_req_taken  input  2  branch resolved taken
i_req_not_taken  input  2  branch resolved not-taken
o_upd_valid  output  1  one-cycle update strobe to predictor
o_upd_pc  output  XLEN  update PC
o_upd_target_pc  output  XLEN  update target
o_upd_taken  output  1  update is taken
o_clear_valid  output  1  clear predictor entry at o_clear_index this cycle
o_clear_index  output  INDEX_WIDTH  entry being cleared
o_busy  output  1  high whenever state is not RUN

Behaviour:
- Interface: one clock, i_clk. Reset is asynchronous and active-low on i_rst_n.
- Reset state:
  - state DISABLED, both FIFOs empty, round-robin pointer set to 0.
  - All outputs 0, except o_busy, which is 1.
- FSM, all transitions registered:
  - DISABLED: o_req_ready=0. If i_enable=1, go to CLEAR with clear index 0.
  - CLEAR:
    - o_clear_valid=1 and o_clear_index=counter; counter increments by 1 per cycle.
    - Cycle with index ENTRIES-1 is the last; next state is RUN.
    - If i_enable=0 in any CLEAR cycle, go to DISABLED and reset the counter. That cycle's clear still asserts.
    - o_req_ready=0.
  - RUN:
    - o_req_ready[n] = FIFO n not full. Full is based on occupancy only; a same-cycle pop does not raise ready.
    - If i_enable=0, go to DISABLED, flush both FIFOs, and force o_upd_valid=0 from the next cycle onward.
- Accept: request n is accepted when i_req_valid[n] & o_req_ready[n].
  - If taken=0 and not_taken=0, the request is accepted and discarded, not queued.
  - If both are 1, it is treated as taken.
  - Queued fields: pc, target_pc, taken.
- Arbitration: each cycle in RUN, if any FIFO is non-empty, pop exactly one head.
  - If both FIFOs are non-empty, the grant goes to the requester indicated by the rr pointer.
  - The rr pointer moves to the other requester after each grant.
  - If only one FIFO is non-empty, it is granted; the pointer still moves to the other requester.
- Output register: the popped entry drives o_upd_* in the next cycle, with o_upd_valid=1 for exactly one cycle per pop.
  - o_upd_pc, o_upd_target_pc and o_upd_taken hold their last value when valid=0.
  - There is no backpressure from the predictor.
- Latency: a request accepted at edge E with the FIFO empty is popped at edge E+1. o_upd_valid is high in the cycle after edge E+1.
- Throughput: 1 update per cycle sustained. Per-requester order is preserved. There is no ordering guarantee across requesters.
- FIFO pointers wrap modulo FIFO_DEPTH. A full flag distinguishes full from empty.
- o_clear_valid and o_upd_valid are never high in the same cycle.

Test Plan:
- Reset, i_enable=1 at cycle 0 -> o_clear_valid high for exactly 128 cycles, index 0..127; o_busy falls when RUN is entered; o_req_ready=2'b11 afterwards.
- RUN, requester 0 sends pc=0x100, target=0x200, taken=1 at edge E -> o_upd_valid=1 with pc=0x100, target=0x200, taken=1 in the cycle after E+1 only.
- Both requesters push 2 entries in the same cycles (A0,A1 / B0,B1), rr=0 -> update order A0,B0,A1,B1 in four consecutive cycles.
- Hold requester 0 valid with FIFO_DEPTH=2 and no pops possible during CLEAR -> ready=0 throughout CLEAR; in RUN, ready drops after 2 accepts when pushes outpace pops.
- Request with taken=0, not_taken=0 -> accepted, no o_upd_valid ever produced. Request with taken=1 and not_taken=1 -> o_upd_taken=1.
- i_enable dropped at CLEAR index 50, and separately in RUN with 2 queued entries -> DISABLED next cycle, FIFOs emptied, no further o_upd_valid. Re-enable restarts clear at index 0.
- Assert i_rst_n=0 mid-CLEAR -> all outputs 0 immediately (o_busy=1); state DISABLED.

Source files
------------

// File: rtl/rice_core_bp_update_scheduler.sv
// Branch predictor update scheduler: per-requester FIFOs with round-robin issue
// onto the single predictor update port, gated by a full-table clear sequence.
module rice_core_bp_update_scheduler #(
  parameter int XLEN        = 32,
  parameter int ENTRIES     = 128,
  parameter int INDEX_WIDTH = $clog2(ENTRIES),
  parameter int FIFO_DEPTH  = 2
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_enable,
  input  logic [1:0]             i_req_valid,
  output logic [1:0]             o_req_ready,
  input  logic [2*XLEN-1:0]      i_req_pc,
  input  logic [2*XLEN-1:0]      i_req_target_pc,
  input  logic [1:0]             i_req_taken,
  input  logic [1:0]             i_req_not_taken,
  output logic                   o_upd_valid,
  output logic [XLEN-1:0]        o_upd_pc,
  output logic [XLEN-1:0]        o_upd_target_pc,
  output logic                   o_upd_taken,
  output logic                   o_clear_valid,
  output logic [INDEX_WIDTH-1:0] o_clear_index,
  output logic                   o_busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W-1:0]       PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [INDEX_WIDTH-1:0] IDX_LAST = INDEX_WIDTH'(ENTRIES - 1);

  typedef enum logic [1:0] {
    ST_DISABLED = 2'd0,
    ST_CLEAR    = 2'd1,
    ST_RUN      = 2'd2
  } state_t;

  state_t                 state_r;
  logic [INDEX_WIDTH-1:0] clear_idx_r;
  logic                   rr_r;
  logic [XLEN-1:0]        pc_mem_r    [2][FIFO_DEPTH];
  logic [XLEN-1:0]        tgt_mem_r   [2][FIFO_DEPTH];
  logic                   taken_mem_r [2][FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r    [2];
  logic [PTR_W-1:0]       rd_ptr_r    [2];
  logic [1:0]             full_r;
  logic                   upd_valid_r;
  logic [XLEN-1:0]        upd_pc_r;
  logic [XLEN-1:0]        upd_tgt_r;
  logic                   upd_taken_r;

  logic                   run_s;
  logic [1:0]             ready_s;
  logic [1:0]             nonempty_s;
  logic [1:0]             push_s;
  logic [1:0]             pop_s;
  logic                   grant_s;

  // Pointers wrap explicitly so non-power-of-two-safe and depth-1 FIFOs both work.
  function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
  endfunction

  // Accept, discard, and round-robin grant decisions for the current cycle.
  always_comb begin
    run_s      = (state_r == ST_RUN);
    ready_s    = 2'b00;
    nonempty_s = 2'b00;
    push_s     = 2'b00;
    pop_s      = 2'b00;
    grant_s    = 1'b0;
    for (int n = 0; n < 2; n++) begin
      nonempty_s[n] = full_r[n] | (wr_ptr_r[n] != rd_ptr_r[n]);
      if (run_s) begin
        ready_s[n] = ~full_r[n];
      end else begin
        ready_s[n] = 1'b0;
      end
      push_s[n] = i_req_valid[n] & ready_s[n] & (i_req_taken[n] | i_req_not_taken[n]);
    end
    if (nonempty_s == 2'b11) begin
      grant_s = rr_r;
    end else if (nonempty_s[0]) begin
      grant_s = 1'b0;
    end else begin
      grant_s = 1'b1;
    end
    if (run_s && (nonempty_s != 2'b00)) begin
      pop_s[grant_s] = 1'b1;
    end else begin
      pop_s = 2'b00;
    end
  end

  // Enable/clear sequencing, FIFO storage and the registered update port.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= ST_DISABLED;
      clear_idx_r <= '0;
      rr_r        <= 1'b0;
      full_r      <= 2'b00;
      upd_valid_r <= 1'b0;
      upd_pc_r    <= '0;
      upd_tgt_r   <= '0;
      upd_taken_r <= 1'b0;
      for (int n = 0; n < 2; n++) begin
        wr_ptr_r[n] <= '0;
        rd_ptr_r[n] <= '0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
          pc_mem_r[n][k]    <= '0;
          tgt_mem_r[n][k]   <= '0;
          taken_mem_r[n][k] <= 1'b0;
        end
      end
    end else begin
      upd_valid_r <= 1'b0;
      case (state_r)
        ST_DISABLED: begin
          clear_idx_r <= '0;
          if (i_enable) state_r <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (!i_enable) begin
            state_r     <= ST_DISABLED;
            clear_idx_r <= '0;
          end else if (clear_idx_r == IDX_LAST) begin
            state_r     <= ST_RUN;
            clear_idx_r <= '0;
          end else begin
            clear_idx_r <= clear_idx_r + INDEX_WIDTH'(1);
          end
        end
        ST_RUN: begin
          if (!i_enable) state_r <= ST_DISABLED;
        end
        default: begin
          state_r     <= ST_DISABLED;
          clear_idx_r <= '0;
        end
      endcase

      // Leaving RUN drops everything queued and suppresses this cycle's pop.
      if (run_s && !i_enable) begin
        full_r <= 2'b00;
        for (int n = 0; n < 2; n++) begin
          wr_ptr_r[n] <= '0;
          rd_ptr_r[n] <= '0;
        end
      end else begin
        for (int n = 0; n < 2; n++) begin
          if (push_s[n]) begin
            pc_mem_r[n][wr_ptr_r[n]]    <= i_req_pc[n*XLEN +: XLEN];
            tgt_mem_r[n][wr_ptr_r[n]]   <= i_req_target_pc[n*XLEN +: XLEN];
            taken_mem_r[n][wr_ptr_r[n]] <= i_req_taken[n];
            wr_ptr_r[n]                 <= inc_ptr(wr_ptr_r[n]);
          end
          if (pop_s[n]) rd_ptr_r[n] <= inc_ptr(rd_ptr_r[n]);
          if (push_s[n] && !pop_s[n] && (inc_ptr(wr_ptr_r[n]) == rd_ptr_r[n])) begin
            full_r[n] <= 1'b1;
          end else if (pop_s[n] && !push_s[n]) begin
            full_r[n] <= 1'b0;
          end
        end
        if (pop_s != 2'b00) begin
          upd_valid_r <= 1'b1;
          upd_pc_r    <= pc_mem_r[grant_s][rd_ptr_r[grant_s]];
          upd_tgt_r   <= tgt_mem_r[grant_s][rd_ptr_r[grant_s]];
          upd_taken_r <= taken_mem_r[grant_s][rd_ptr_r[grant_s]];
          rr_r        <= ~grant_s;
        end
      end
    end
  end

  assign o_req_ready     = ready_s;
  assign o_upd_valid     = upd_valid_r;
  assign o_upd_pc        = upd_pc_r;
  assign o_upd_target_pc = upd_tgt_r;
  assign o_upd_taken     = upd_taken_r;
  assign o_clear_valid   = (state_r == ST_CLEAR);
  assign o_clear_index   = clear_idx_r;
  assign o_busy          = (state_r != ST_RUN);

endmodule

// File: tb/tb_rice_core_bp_update_scheduler.sv
// Randomized bench for rice_core_bp_update_scheduler, compared each cycle
// against a queue-based behavioural model of the scheduler.
module tb_rice_core_bp_update_scheduler;

  localparam int XLEN    = 32;
  localparam int ENTRIES = 128;
  localparam int IW      = 7;
  localparam int DEPTH   = 2;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_enable;
  logic [1:0]        i_req_valid;
  logic [1:0]        o_req_ready;
  logic [2*XLEN-1:0] i_req_pc;
  logic [2*XLEN-1:0] i_req_target_pc;
  logic [1:0]        i_req_taken;
  logic [1:0]        i_req_not_taken;
  logic              o_upd_valid;
  logic [XLEN-1:0]   o_upd_pc;
  logic [XLEN-1:0]   o_upd_target_pc;
  logic              o_upd_taken;
  logic              o_clear_valid;
  logic [IW-1:0]     o_clear_index;
  logic              o_busy;

  always #5 i_clk = ~i_clk;

  rice_core_bp_update_scheduler #(
    .XLEN(XLEN), .ENTRIES(ENTRIES), .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_pc(i_req_pc), .i_req_target_pc(i_req_target_pc),
    .i_req_taken(i_req_taken), .i_req_not_taken(i_req_not_taken),
    .o_upd_valid(o_upd_valid), .o_upd_pc(o_upd_pc),
    .o_upd_target_pc(o_upd_target_pc), .o_upd_taken(o_upd_taken),
    .o_clear_valid(o_clear_valid), .o_clear_index(o_clear_index),
    .o_busy(o_busy)
  );

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] tgt;
    logic            tk;
  } upd_t;

  // Model: mode 0 = predictor off, 1 = clearing table, 2 = issuing updates.
  upd_t q0[$];
  upd_t q1[$];
  int   m_mode;
  int   m_cnt;
  bit   m_rr;
  bit   m_uv;
  upd_t m_upd;
  int   checks;
  int   errors;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_mode = 0;
    m_cnt  = 0;
    m_rr   = 1'b0;
    m_uv   = 1'b0;
    m_upd  = '0;
  endtask

  task automatic compare_outputs();
    logic [1:0] er;
    er[0] = (m_mode == 2) && (q0.size() < DEPTH);
    er[1] = (m_mode == 2) && (q1.size() < DEPTH);
    check_eq("ready",       64'(o_req_ready),     64'(er));
    check_eq("clear_valid", 64'(o_clear_valid),   64'(m_mode == 1));
    check_eq("clear_index", 64'(o_clear_index),   64'(m_cnt));
    check_eq("busy",        64'(o_busy),          64'(m_mode != 2));
    check_eq("upd_valid",   64'(o_upd_valid),     64'(m_uv));
    check_eq("upd_pc",      64'(o_upd_pc),        64'(m_upd.pc));
    check_eq("upd_target",  64'(o_upd_target_pc), 64'(m_upd.tgt));
    check_eq("upd_taken",   64'(o_upd_taken),     64'(m_upd.tk));
  endtask

  // One clock: check current outputs, drive new inputs, advance the model.
  task automatic step(input bit en, input bit [1:0] v, input bit [1:0] t, input bit [1:0] nt);
    upd_t     r[2];
    bit [1:0] acc;
    int       g;
    compare_outputs();
    i_enable        = en;
    i_req_valid     = v;
    i_req_taken     = t;
    i_req_not_taken = nt;
    for (int n = 0; n < 2; n++) begin
      r[n].pc  = $urandom;
      r[n].tgt = $urandom;
      r[n].tk  = t[n];
      i_req_pc[n*XLEN +: XLEN]        = r[n].pc;
      i_req_target_pc[n*XLEN +: XLEN] = r[n].tgt;
    end
    m_uv = 1'b0;
    case (m_mode)
      0: begin
        if (en) begin m_mode = 1; m_cnt = 0; end
      end
      1: begin
        if (!en) begin
          m_mode = 0; m_cnt = 0;
        end else if (m_cnt == ENTRIES - 1) begin
          m_mode = 2; m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end
      default: begin
        if (!en) begin
          q0.delete();
          q1.delete();
          m_mode = 0;
        end else begin
          acc[0] = v[0] && (q0.size() < DEPTH);
          acc[1] = v[1] && (q1.size() < DEPTH);
          if (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) g = m_rr ? 1 : 0;
            else g = (q0.size() > 0) ? 0 : 1;
            if (g == 0) m_upd = q0.pop_front();
            else        m_upd = q1.pop_front();
            m_uv = 1'b1;
            m_rr = (g == 0);
          end
          if (acc[0] && (t[0] || nt[0])) q0.push_back(r[0]);
          if (acc[1] && (t[1] || nt[1])) q1.push_back(r[1]);
        end
      end
    endcase
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic rand_steps(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 2'($urandom), 2'($urandom), 2'($urandom));
  endtask

  task automatic idle_steps(input int n, input bit en);
    for (int i = 0; i < n; i++) step(en, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    i_rst_n         = 1'b0;
    i_enable        = 1'b0;
    i_req_valid     = 2'b00;
    i_req_pc        = '0;
    i_req_target_pc = '0;
    i_req_taken     = 2'b00;
    i_req_not_taken = 2'b00;
    model_reset();
    repeat (2) @(negedge i_clk);
    compare_outputs();
    i_rst_n = 1'b1;

    // Full clear with requesters hammering; ready must stay low.
    for (int i = 0; i < 132; i++) step(1'b1, 2'b11, 2'($urandom), 2'($urandom));
    // Single request, then paired pushes, then discard and taken+not_taken.
    step(1'b1, 2'b01, 2'b01, 2'b00);
    idle_steps(3, 1'b1);
    step(1'b1, 2'b11, 2'b11, 2'b00);
    step(1'b1, 2'b11, 2'b10, 2'b01);
    idle_steps(5, 1'b1);
    step(1'b1, 2'b01, 2'b00, 2'b00);
    step(1'b1, 2'b10, 2'b10, 2'b10);
    idle_steps(4, 1'b1);
    rand_steps(400, 1'b1);
    // Drop enable in RUN with entries queued, then re-enable.
    step(1'b1, 2'b11, 2'b11, 2'b00);
    step(1'b1, 2'b11, 2'b11, 2'b00);
    rand_steps(4, 1'b0);
    // Drop enable at clear index 50, sit disabled, then full clear again.
    for (int i = 0; i < 51; i++) step(1'b1, 2'($urandom), 2'($urandom), 2'($urandom));
    rand_steps(3, 1'b0);
    rand_steps(140, 1'b1);
    rand_steps(150, 1'b1);
    // Asynchronous reset in the middle of a clear sequence.
    rand_steps(2, 1'b0);
    rand_steps(60, 1'b1);
    #2 i_rst_n = 1'b0;
    #1 model_reset();
    compare_outputs();
    @(negedge i_clk);
    compare_outputs();
    i_rst_n = 1'b1;
    rand_steps(135, 1'b1);
    rand_steps(200, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
